// File: rtl/uart_status_tx.sv
// uart_status_tx: snapshots snake game state and sends a fixed 4-byte status
// packet (A5, score, status, checksum) as 8N1 frames on its own TX line.
// A request comes from report_req or a game_over rising edge; one further
// request can be queued while a packet is in flight.
module uart_status_tx #(
  parameter int unsigned BPS         = 9600,
  parameter int unsigned SYS_CLK_FRE = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       report_req,
  input  logic       game_over,
  input  logic [7:0] score,
  input  logic [2:0] direction,
  input  logic [1:0] mode,
  input  logic       pause,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       pkt_done
);

  localparam int unsigned BIT_CNT   = SYS_CLK_FRE / BPS;
  localparam int unsigned CNT_W     = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [3:0]  STOP_IDX  = 4'd9;
  localparam logic [1:0]  LAST_BYTE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t           state;
  logic             game_over_d;
  logic             pending;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_idx;
  logic [1:0]       byte_idx;
  logic [31:0]      pkt;

  logic             req_c;
  logic [7:0]       stat_c;
  logic [31:0]      snap_c;
  logic             next_bit_c;
  logic             baud_last_c;

  // Request detect, packet snapshot image and the line level of the next bit.
  always_comb begin
    req_c       = report_req | (game_over & ~game_over_d);
    stat_c      = {game_over, pause, mode, 1'b0, direction};
    snap_c      = {SYNC_BYTE ^ score ^ stat_c, stat_c, score, SYNC_BYTE};
    baud_last_c = (baud_cnt == CNT_W'(BIT_CNT - 1));
    // Bit index 0..7 here is the data bit that follows the current one;
    // after data bit 7 (index 8) comes the stop bit.
    next_bit_c  = 1'b1;
    if (bit_idx < 4'd8) begin
      next_bit_c = pkt[{byte_idx, bit_idx[2:0]}];
    end
  end

  // Packet FSM with registered line, busy and done outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      game_over_d <= 1'b0;
      pending     <= 1'b0;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      pkt         <= '0;
      uart_txd    <= 1'b1;
      tx_busy     <= 1'b0;
      pkt_done    <= 1'b0;
    end else begin
      game_over_d <= game_over;
      pkt_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          uart_txd <= 1'b1;
          tx_busy  <= 1'b0;
          // pending can only be set here by a request taken in the DONE cycle
          if (req_c || pending) begin
            pkt      <= snap_c;
            pending  <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            uart_txd <= 1'b0;
            tx_busy  <= 1'b1;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          // one-deep queue: a request while one is pending is simply lost
          if (req_c) begin
            pending <= 1'b1;
          end
          if (baud_last_c) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_IDX) begin
              bit_idx <= '0;
              if (byte_idx == LAST_BYTE) begin
                uart_txd <= 1'b1;
                pkt_done <= 1'b1;
                tx_busy  <= pending | req_c;
                state    <= ST_DONE;
              end else begin
                byte_idx <= byte_idx + 2'd1;
                uart_txd <= 1'b0;
              end
            end else begin
              bit_idx  <= bit_idx + 4'd1;
              uart_txd <= next_bit_c;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          uart_txd <= 1'b1;
          // a request seen now queues behind whatever follows this cycle
          pending  <= req_c;
          if (pending) begin
            pkt      <= snap_c;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            uart_txd <= 1'b0;
            tx_busy  <= 1'b1;
            state    <= ST_SEND;
          end else begin
            tx_busy <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_status_tx.sv
// Testbench for uart_status_tx: records the line, busy and done per cycle and
// decodes packets mid-bit, comparing against a byte-level packet model.
module tb_uart_status_tx;

  localparam int SYS_CLK_FRE = 1000;
  localparam int BPS         = 100;
  localparam int BIT_CNT     = SYS_CLK_FRE / BPS;
  localparam int MAXC        = 16384;

  logic       sys_clk    = 1'b0;
  logic       sys_rst_n  = 1'b0;
  logic       report_req = 1'b0;
  logic       game_over  = 1'b0;
  logic [7:0] score      = 8'h00;
  logic [2:0] direction  = 3'b000;
  logic [1:0] mode       = 2'b00;
  logic       pause      = 1'b0;
  logic       uart_txd;
  logic       tx_busy;
  logic       pkt_done;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  logic txd_tr  [MAXC];
  logic busy_tr [MAXC];
  logic done_tr [MAXC];

  uart_status_tx #(
    .BPS         (BPS),
    .SYS_CLK_FRE (SYS_CLK_FRE)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .report_req (report_req),
    .game_over  (game_over),
    .score      (score),
    .direction  (direction),
    .mode       (mode),
    .pause      (pause),
    .uart_txd   (uart_txd),
    .tx_busy    (tx_busy),
    .pkt_done   (pkt_done)
  );

  always #5 sys_clk = ~sys_clk;

  // cycle number: cycle k lies between posedge k and posedge k+1
  always @(posedge sys_clk) cyc <= cyc + 1;

  // per-cycle trace, sampled mid-cycle
  always @(negedge sys_clk) begin
    if (cyc < MAXC) begin
      txd_tr[cyc]  <= uart_txd;
      busy_tr[cyc] <= tx_busy;
      done_tr[cyc] <= pkt_done;
    end
  end

  // Reference packet: sync byte, score, status byte, XOR of the first three.
  function automatic logic [31:0] model_pkt(input logic [7:0] sc, input logic [2:0] dir,
                                            input logic [1:0] md, input logic ps,
                                            input logic go);
    logic [7:0] b [4];
    b[0] = 8'hA5;
    b[1] = sc;
    b[2] = {go, ps, md, 1'b0, dir};
    b[3] = b[0] ^ b[1] ^ b[2];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // UART receiver on the trace: start bit begins at cycle s, sample mid-bit.
  function automatic void decode(input int s, output logic [31:0] data, output int ferr);
    int   t;
    logic v;
    ferr = 0;
    data = '0;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 10; i++) begin
        t = s + (10 * j + i) * BIT_CNT + BIT_CNT / 2;
        v = (t < MAXC) ? txd_tr[t] : 1'bx;
        if (i == 0) begin
          if (v !== 1'b0) ferr++;
        end else if (i == 9) begin
          if (v !== 1'b1) ferr++;
        end else begin
          data[8 * j + i - 1] = v;
        end
      end
    end
  endfunction

  // Number of cycles in [a,b] where the chosen trace (0 txd, 1 busy, 2 done) equals v.
  function automatic int count_eq(input int sel, input int a, input int b, input logic v);
    int   c;
    logic x;
    c = 0;
    for (int t = a; t <= b; t++) begin
      if (t >= MAXC || t < 0) x = 1'bx;
      else if (sel == 0)      x = txd_tr[t];
      else if (sel == 1)      x = busy_tr[t];
      else                    x = done_tr[t];
      if (x === v) c++;
    end
    return c;
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Request in the current cycle; returns that cycle number.
  task automatic pulse_req(output int n);
    report_req = 1'b1;
    n = cyc;
    @(posedge sys_clk);
    #1;
    report_req = 1'b0;
  endtask

  task automatic set_inputs(input logic [7:0] sc, input logic [2:0] dir,
                            input logic [1:0] md, input logic ps);
    score     = sc;
    direction = dir;
    mode      = md;
    pause     = ps;
  endtask

  task automatic test_reset();
    int s;
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if ({uart_txd, tx_busy, pkt_done} !== 3'b100) begin
      failures++;
      $display("FAIL reset_outputs: txd/busy/done=%b required 100", {uart_txd, tx_busy, pkt_done});
    end
    sys_rst_n = 1'b1;
    s = cyc;
    wait_until(s + 1001);
    checks++;
    if (count_eq(0, s, s + 999, 1'b1) != 1000) begin
      failures++;
      $display("FAIL idle_txd: high cycles=%0d required 1000", count_eq(0, s, s + 999, 1'b1));
    end
    checks++;
    if (count_eq(1, s, s + 999, 1'b0) != 1000) begin
      failures++;
      $display("FAIL idle_busy: low cycles=%0d required 1000", count_eq(1, s, s + 999, 1'b0));
    end
    checks++;
    if (count_eq(2, s, s + 999, 1'b0) != 1000) begin
      failures++;
      $display("FAIL idle_done: low cycles=%0d required 1000", count_eq(2, s, s + 999, 1'b0));
    end
  endtask

  task automatic test_single_packet();
    int n, ferr;
    logic [31:0] got;
    set_inputs(8'h07, 3'b010, 2'b01, 1'b0);
    pulse_req(n);
    wait_until(n + 411);
    decode(n + 1, got, ferr);
    checks++;
    if ({txd_tr[n], txd_tr[n + 1]} !== 2'b10) begin
      failures++;
      $display("FAIL single_start_edge: txd[N],txd[N+1]=%b required 10", {txd_tr[n], txd_tr[n + 1]});
    end
    checks++;
    if (got !== 32'hB01207A5 || ferr != 0) begin
      failures++;
      $display("FAIL single_bytes: got %h ferr=%0d required b01207a5 ferr=0", got, ferr);
    end
    checks++;
    if (done_tr[n + 401] !== 1'b1 || count_eq(2, n, n + 410, 1'b1) != 1) begin
      failures++;
      $display("FAIL single_done: done[N+401]=%b pulses=%0d required 1 and 1",
               done_tr[n + 401], count_eq(2, n, n + 410, 1'b1));
    end
    checks++;
    if (count_eq(1, n + 1, n + 400, 1'b1) != 400 || busy_tr[n] !== 1'b0 || busy_tr[n + 401] !== 1'b0) begin
      failures++;
      $display("FAIL single_busy: high=%0d busy[N]=%b busy[N+401]=%b required 400,0,0",
               count_eq(1, n + 1, n + 400, 1'b1), busy_tr[n], busy_tr[n + 401]);
    end
  endtask

  task automatic test_snapshot();
    int n, ferr;
    logic [31:0] got;
    set_inputs(8'h07, 3'b010, 2'b01, 1'b0);
    pulse_req(n);
    wait_until(n + 50);
    score = 8'hFF;
    wait_until(n + 411);
    decode(n + 1, got, ferr);
    checks++;
    if (got !== 32'hB01207A5 || ferr != 0) begin
      failures++;
      $display("FAIL snapshot_bytes: got %h ferr=%0d required b01207a5 ferr=0", got, ferr);
    end
    score = 8'h07;
  endtask

  task automatic test_game_over();
    int n, ferr;
    logic [31:0] got;
    set_inputs(8'h20, 3'b001, 2'b10, 1'b1);
    game_over = 1'b1;
    n = cyc;
    wait_until(n + 1301);
    decode(n + 1, got, ferr);
    checks++;
    if ({txd_tr[n], txd_tr[n + 1]} !== 2'b10) begin
      failures++;
      $display("FAIL gameover_start: txd[N],txd[N+1]=%b required 10", {txd_tr[n], txd_tr[n + 1]});
    end
    checks++;
    if (got !== 32'h64E120A5 || ferr != 0) begin
      failures++;
      $display("FAIL gameover_bytes: got %h ferr=%0d required 64e120a5 ferr=0", got, ferr);
    end
    checks++;
    if (count_eq(0, n + 402, n + 1300, 1'b0) != 0 || count_eq(2, n, n + 1300, 1'b1) != 1) begin
      failures++;
      $display("FAIL gameover_single: low cycles after=%0d done pulses=%0d required 0 and 1",
               count_eq(0, n + 402, n + 1300, 1'b0), count_eq(2, n, n + 1300, 1'b1));
    end
    game_over = 1'b0;
    wait_until(cyc + 5);
  endtask

  task automatic test_pending();
    int n, m, ferr;
    logic [31:0] got, exp;
    set_inputs(8'($urandom), 3'($urandom), 2'($urandom), 1'($urandom));
    exp = model_pkt(score, direction, mode, pause, 1'b0);
    pulse_req(n);
    wait_until(n + 100);
    pulse_req(m);
    wait_until(n + 200);
    pulse_req(m);
    wait_until(n + 1301);
    decode(n + 1, got, ferr);
    checks++;
    if (got !== exp || ferr != 0) begin
      failures++;
      $display("FAIL pending_first: got %h ferr=%0d required %h ferr=0", got, ferr, exp);
    end
    checks++;
    if ({txd_tr[n + 401], txd_tr[n + 402]} !== 2'b10) begin
      failures++;
      $display("FAIL pending_second_start: txd[N+401],txd[N+402]=%b required 10",
               {txd_tr[n + 401], txd_tr[n + 402]});
    end
    decode(n + 402, got, ferr);
    checks++;
    if (got !== exp || ferr != 0) begin
      failures++;
      $display("FAIL pending_second: got %h ferr=%0d required %h ferr=0", got, ferr, exp);
    end
    checks++;
    if (count_eq(1, n + 1, n + 801, 1'b1) != 801 || busy_tr[n + 802] !== 1'b0) begin
      failures++;
      $display("FAIL pending_busy: high=%0d busy[N+802]=%b required 801 and 0",
               count_eq(1, n + 1, n + 801, 1'b1), busy_tr[n + 802]);
    end
    checks++;
    if (done_tr[n + 401] !== 1'b1 || done_tr[n + 802] !== 1'b1 || count_eq(2, n, n + 1300, 1'b1) != 2) begin
      failures++;
      $display("FAIL pending_done: done[N+401]=%b done[N+802]=%b pulses=%0d required 1,1,2",
               done_tr[n + 401], done_tr[n + 802], count_eq(2, n, n + 1300, 1'b1));
    end
    checks++;
    if (count_eq(0, n + 803, n + 1300, 1'b0) != 0) begin
      failures++;
      $display("FAIL pending_drop: low cycles after second=%0d required 0",
               count_eq(0, n + 803, n + 1300, 1'b0));
    end
  endtask

  task automatic test_reset_mid_packet();
    int n, n2, ferr;
    logic [31:0] got, exp;
    set_inputs(8'h5A, 3'b100, 2'b11, 1'b0);
    pulse_req(n);
    wait_until(n + 150);
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({uart_txd, tx_busy, pkt_done} !== 3'b100) begin
      failures++;
      $display("FAIL midreset_outputs: txd/busy/done=%b required 100", {uart_txd, tx_busy, pkt_done});
    end
    wait_until(n + 155);
    sys_rst_n = 1'b1;
    wait_until(n + 158);
    set_inputs(8'($urandom), 3'($urandom), 2'($urandom), 1'($urandom));
    exp = model_pkt(score, direction, mode, pause, 1'b0);
    pulse_req(n2);
    wait_until(n2 + 411);
    checks++;
    if (count_eq(0, n + 151, n2, 1'b0) != 0) begin
      failures++;
      $display("FAIL midreset_quiet: low cycles after reset=%0d required 0", count_eq(0, n + 151, n2, 1'b0));
    end
    decode(n2 + 1, got, ferr);
    checks++;
    if (got !== exp || ferr != 0 || done_tr[n2 + 401] !== 1'b1) begin
      failures++;
      $display("FAIL midreset_packet: got %h ferr=%0d done=%b required %h ferr=0 done=1",
               got, ferr, done_tr[n2 + 401], exp);
    end
  endtask

  task automatic test_random_packets();
    int n, ferr, chg;
    logic [31:0] got, exp;
    for (int k = 0; k < 6; k++) begin
      set_inputs(8'($urandom), 3'($urandom), 2'($urandom), 1'($urandom));
      exp = model_pkt(score, direction, mode, pause, 1'b0);
      pulse_req(n);
      chg = int'($urandom_range(2, 390));
      wait_until(n + chg);
      set_inputs(8'($urandom), 3'($urandom), 2'($urandom), 1'($urandom));
      wait_until(n + 402 + int'($urandom_range(0, 20)));
      decode(n + 1, got, ferr);
      checks++;
      if (got !== exp || ferr != 0) begin
        failures++;
        $display("FAIL random_bytes[%0d]: got %h ferr=%0d required %h ferr=0", k, got, ferr, exp);
      end
      checks++;
      if (txd_tr[n + 1] !== 1'b0 || done_tr[n + 401] !== 1'b1 || done_tr[n + 400] !== 1'b0) begin
        failures++;
        $display("FAIL random_timing[%0d]: txd[N+1]=%b done[N+400]=%b done[N+401]=%b required 0,0,1",
                 k, txd_tr[n + 1], done_tr[n + 400], done_tr[n + 401]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_snapshot();
    test_game_over();
    test_pending();
    test_reset_mid_packet();
    test_random_packets();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
